// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices and sequencer state encoding
// Purpose : stage numbering for the 7-stage core and the pipe_ctrl FSM states.
// Contents: NUM_STG, stage_e (STG_IF=0 .. STG_WB=6), pipe_state_e {RUN, DRAIN, HALT}.
package pipe_ctrl_pkg;

   localparam int NUM_STG = 7;

   typedef enum logic [2:0] {
      STG_IF  = 3'd0,
      STG_ID  = 3'd1,
      STG_RD  = 3'd2,
      STG_EX  = 3'd3,
      STG_MEM = 3'd4,
      STG_ASM = 3'd5,
      STG_WB  = 3'd6
   } stage_e;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// rtl/pipe_ctrl_stall_wdog.sv - consecutive-stall counter with sticky deadlock flag
// Purpose : counts back-to-back stall cycles, saturates, and latches a deadlock error.
// Ports   : i_clk, i_rst      clock, synchronous active-high reset
//           i_count_en        1 while the pipeline is live (RUN/DRAIN); counter holds otherwise
//           i_stall           this cycle is a stall cycle
//           o_stall_cycles    consecutive stall count, saturating at all ones
//           o_deadlock_err    sticky, set when a stall cycle sees count == STALL_LIMIT-1
module pipe_ctrl_stall_wdog #(
   parameter int CNT_W       = 12,
   parameter int STALL_LIMIT = 1024
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_count_en,
   input  logic             i_stall,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic             o_deadlock_err
);

   localparam logic [CNT_W-1:0] C_MAX  = '1;
   localparam logic [CNT_W-1:0] C_TRIP = CNT_W'(STALL_LIMIT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (i_count_en) begin
         if (i_stall) begin
            if (r_cnt != C_MAX) begin
               r_cnt <= r_cnt + 1'b1;
            end
            // The limit stall cycle itself raises the flag, so it is visible
            // together with stall_cycles == STALL_LIMIT.
            if (r_cnt == C_TRIP) begin
               r_err <= 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_stall_cycles = r_cnt;
   assign o_deadlock_err = r_err;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer producing per-stage advance/kill controls
// Purpose : turns stall, memory back-pressure, redirect, drain and halt requests into
//           stage advance/kill enables for IF ID RD EX MEM ASM WB.
// Ports   : i_clk, i_rst                     clock, synchronous active-high reset
//           i_ex_stall_flag, i_mem_busy      stall sources (EX operand, MEM back-pressure)
//           i_ex_redirect                    1-cycle mispredict pulse from EX
//           i_drain_req, i_halt_req          level requests: empty / freeze the pipeline
//           i_stg_valid                      valid bit of each stage register
//           o_stg_adv, o_stg_kill            per-stage load / bubble controls (kill wins)
//           o_hzd_en                         hazard unit enable
//           o_drain_done, o_halted           drain completion pulse, frozen indicator
//           o_stall_cycles, o_deadlock_err   stall watchdog outputs
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W       = 12,
   parameter int STALL_LIMIT = 1024
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_ex_stall_flag,
   input  logic               i_mem_busy,
   input  logic               i_ex_redirect,
   input  logic               i_drain_req,
   input  logic               i_halt_req,
   input  logic [NUM_STG-1:0] i_stg_valid,
   output logic [NUM_STG-1:0] o_stg_adv,
   output logic [NUM_STG-1:0] o_stg_kill,
   output logic               o_hzd_en,
   output logic               o_drain_done,
   output logic               o_halted,
   output logic [CNT_W-1:0]   o_stall_cycles,
   output logic               o_deadlock_err
);

   // IF is still fetching wrong-path/new work during a drain; only ID..WB must empty.
   localparam logic [NUM_STG-1:0] C_DRAIN_MASK = ~NUM_STG'(1);

   pipe_state_e        r_state;
   pipe_state_e        w_state_nxt;
   logic               r_redirect_pend;
   logic               w_redirect_pend_nxt;
   logic               r_drain_done;
   logic               w_drain_done_nxt;
   logic [NUM_STG-1:0] w_adv;
   logic [NUM_STG-1:0] w_kill;
   logic               w_hzd_en;
   logic               w_live;
   logic               w_drained;
   logic [CNT_W-1:0]   w_stall_cycles;
   logic               w_deadlock_err;

   assign w_live    = (r_state != HALT);
   assign w_drained = ((i_stg_valid & C_DRAIN_MASK) == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= RUN;
         r_redirect_pend <= 1'b0;
         r_drain_done    <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_redirect_pend <= w_redirect_pend_nxt;
         r_drain_done    <= w_drain_done_nxt;
      end
   end

   always_comb begin
      w_adv               = '0;
      w_kill              = '0;
      w_hzd_en            = 1'b0;
      w_state_nxt         = r_state;
      w_redirect_pend_nxt = r_redirect_pend;
      w_drain_done_nxt    = 1'b0;

      case (r_state)
         RUN, DRAIN: begin
            w_hzd_en = 1'b1;
            if (i_mem_busy) begin
               // Everything up to MEM holds; ASM gets a bubble; WB retires.
               w_adv[STG_WB]       = 1'b1;
               w_kill[STG_ASM]     = 1'b1;
               w_redirect_pend_nxt = r_redirect_pend | i_ex_redirect;
            end else if (i_ex_stall_flag) begin
               // A redirect seen here is dropped; EX re-raises it once unstalled.
               w_adv[STG_ASM]  = 1'b1;
               w_adv[STG_WB]   = 1'b1;
               w_kill[STG_MEM] = 1'b1;
            end else if (i_ex_redirect || r_redirect_pend) begin
               // Branch moves on into MEM; everything younger is squashed.
               w_adv               = '1;
               w_kill[STG_IF]      = 1'b1;
               w_kill[STG_ID]      = 1'b1;
               w_kill[STG_RD]      = 1'b1;
               w_kill[STG_EX]      = 1'b1;
               w_redirect_pend_nxt = 1'b0;
            end else begin
               w_adv = '1;
            end

            if (r_state == DRAIN) begin
               w_adv[STG_IF]  = 1'b0;
               w_kill[STG_ID] = 1'b1;
               if (w_drained) begin
                  w_drain_done_nxt = 1'b1;
                  w_state_nxt      = RUN;
               end
            end else if (i_halt_req) begin
               // Halt waits for a clean cycle so nothing is frozen mid-stall or mid-redirect.
               if (!i_mem_busy && !i_ex_stall_flag && !r_redirect_pend) begin
                  w_state_nxt = HALT;
               end
            end else if (i_drain_req) begin
               w_state_nxt = DRAIN;
            end
         end
         HALT: begin
            w_redirect_pend_nxt = r_redirect_pend | i_ex_redirect;
            if (!i_halt_req) begin
               w_state_nxt = RUN;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase

      if (i_rst) begin
         w_adv    = '0;
         w_kill   = '1;
         w_hzd_en = 1'b0;
      end
   end

   pipe_ctrl_stall_wdog #(
      .CNT_W       (CNT_W),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall_wdog (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_count_en     (w_live),
      .i_stall        (i_mem_busy | i_ex_stall_flag),
      .o_stall_cycles (w_stall_cycles),
      .o_deadlock_err (w_deadlock_err)
   );

   // Registered outputs are masked while rst is high so the reset values show
   // immediately, not only after the reset edge.
   assign o_stg_adv      = w_adv;
   assign o_stg_kill     = w_kill;
   assign o_hzd_en       = w_hzd_en;
   assign o_drain_done   = r_drain_done & ~i_rst;
   assign o_halted       = (r_state == HALT) & ~i_rst;
   assign o_stall_cycles = i_rst ? '0 : w_stall_cycles;
   assign o_deadlock_err = w_deadlock_err & ~i_rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       es, mb, red, drq, hrq;
   logic [6:0] valid;
   logic [6:0] adv, kill;
   logic       hzd, dd, halted, dl;
   logic [3:0] cnt;

   int errs   = 0;
   int checks = 0;

   // Reference model state: mode 0=running, 1=draining, 2=frozen.
   int m_mode, m_pend, m_cnt, m_dl, m_dd;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(4), .STALL_LIMIT(10)) dut (
      .i_clk(clk), .i_rst(rst), .i_ex_stall_flag(es), .i_mem_busy(mb),
      .i_ex_redirect(red), .i_drain_req(drq), .i_halt_req(hrq), .i_stg_valid(valid),
      .o_stg_adv(adv), .o_stg_kill(kill), .o_hzd_en(hzd), .o_drain_done(dd),
      .o_halted(halted), .o_stall_cycles(cnt), .o_deadlock_err(dl)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      es = 0; mb = 0; red = 0; drq = 0; hrq = 0; valid = 7'h00;
   endtask

   task automatic do_reset();
      rst = 1; clear_inputs();
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; clear_inputs(); valid = 7'h7F;
      tick(); #1;
      checks++; if (adv !== 7'h00)  begin errs++; $display("FAIL rst_adv got=%h exp=00", adv); end
      checks++; if (kill !== 7'h7F) begin errs++; $display("FAIL rst_kill got=%h exp=7f", kill); end
      checks++; if ({hzd, dd, halted, dl} !== 4'b0) begin errs++; $display("FAIL rst_flags got=%b exp=0000", {hzd, dd, halted, dl}); end
      checks++; if (cnt !== 4'd0)   begin errs++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
      // Reset from HALT: outputs revert while rst is high, RUN afterwards.
      rst = 0; hrq = 1; tick();
      checks++; if (halted !== 1'b1) begin errs++; $display("FAIL rst_pre_halt got=%b exp=1", halted); end
      rst = 1; #1;
      checks++; if ({halted, hzd, adv, kill} !== {2'b00, 7'h00, 7'h7F}) begin errs++; $display("FAIL rst_mid got=%b/%b/%h/%h exp=0/0/00/7f", halted, hzd, adv, kill); end
      tick(); rst = 0; hrq = 0; #1;
      checks++; if ({halted, adv} !== {1'b0, 7'h7F}) begin errs++; $display("FAIL rst_after got=%b/%h exp=0/7f", halted, adv); end
   endtask

   task automatic test_idle();
      do_reset(); #2;
      checks++; if (adv !== 7'h7F) begin errs++; $display("FAIL idle_adv got=%h exp=7f", adv); end
      checks++; if (kill !== 7'h00) begin errs++; $display("FAIL idle_kill got=%h exp=00", kill); end
      checks++; if (hzd !== 1'b1) begin errs++; $display("FAIL idle_hzd got=%b exp=1", hzd); end
      checks++; if (cnt !== 4'd0) begin errs++; $display("FAIL idle_cnt got=%0d exp=0", cnt); end
   endtask

   task automatic test_ex_stall();
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         es = 1; #2;
         checks++; if ({adv, kill} !== {7'h60, 7'h10}) begin errs++; $display("FAIL stall_ctl c%0d got=%h/%h exp=60/10", k, adv, kill); end
         tick();
         checks++; if (cnt !== 4'(k)) begin errs++; $display("FAIL stall_cnt c%0d got=%0d exp=%0d", k, cnt, k); end
      end
      es = 0; #2;
      checks++; if ({adv, kill} !== {7'h7F, 7'h00}) begin errs++; $display("FAIL stall_release got=%h/%h exp=7f/00", adv, kill); end
      tick();
      checks++; if (cnt !== 4'd0) begin errs++; $display("FAIL stall_clear got=%0d exp=0", cnt); end
   endtask

   task automatic test_redirect_busy();
      do_reset();
      mb = 1; red = 1; #2;
      checks++; if ({adv, kill} !== {7'h40, 7'h20}) begin errs++; $display("FAIL rdb_c1 got=%h/%h exp=40/20", adv, kill); end
      tick(); red = 0; #2;
      checks++; if ({adv, kill} !== {7'h40, 7'h20}) begin errs++; $display("FAIL rdb_c2 got=%h/%h exp=40/20", adv, kill); end
      tick(); mb = 0; #2;
      checks++; if ({adv, kill} !== {7'h7F, 7'h0F}) begin errs++; $display("FAIL rdb_free got=%h/%h exp=7f/0f", adv, kill); end
      tick(); #2;
      checks++; if ({adv, kill} !== {7'h7F, 7'h00}) begin errs++; $display("FAIL rdb_pend_clr got=%h/%h exp=7f/00", adv, kill); end
      tick();
   endtask

   task automatic test_drain();
      logic [6:0] v;
      do_reset();
      drq = 1; valid = 7'h7E; #2;
      checks++; if ({adv, kill} !== {7'h7F, 7'h00}) begin errs++; $display("FAIL drn_enter got=%h/%h exp=7f/00", adv, kill); end
      tick(); drq = 0;
      for (int k = 0; k <= 6; k++) begin
         v = 7'h7E; v = v << k; valid = v; #2;
         checks++; if ({adv, kill} !== {7'h7E, 7'h02}) begin errs++; $display("FAIL drn_ctl k%0d got=%h/%h exp=7e/02", k, adv, kill); end
         tick();
         checks++; if (dd !== (k == 6)) begin errs++; $display("FAIL drn_done k%0d got=%b exp=%b", k, dd, (k == 6)); end
      end
      #2;
      checks++; if ({adv, kill} !== {7'h7F, 7'h00}) begin errs++; $display("FAIL drn_run got=%h/%h exp=7f/00", adv, kill); end
      tick();
      checks++; if (dd !== 1'b0) begin errs++; $display("FAIL drn_pulse got=%b exp=0", dd); end
   endtask

   task automatic test_halt();
      do_reset();
      hrq = 1; tick();
      checks++; if ({halted, adv, kill, hzd} !== {1'b1, 7'h00, 7'h00, 1'b0}) begin errs++; $display("FAIL hlt_on got=%b/%h/%h/%b exp=1/00/00/0", halted, adv, kill, hzd); end
      red = 1; tick(); red = 0; hrq = 0; #2;
      checks++; if (halted !== 1'b1) begin errs++; $display("FAIL hlt_hold got=%b exp=1", halted); end
      tick(); #1;
      // Redirect received while frozen is applied on the first RUN cycle.
      checks++; if ({halted, adv, kill} !== {1'b0, 7'h7F, 7'h0F}) begin errs++; $display("FAIL hlt_off got=%b/%h/%h exp=0/7f/0f", halted, adv, kill); end
      tick();
   endtask

   task automatic test_deadlock();
      do_reset();
      mb = 1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++; if (cnt !== 4'((k > 15) ? 15 : k)) begin errs++; $display("FAIL dl_cnt k%0d got=%0d exp=%0d", k, cnt, (k > 15) ? 15 : k); end
         checks++; if (dl !== (k >= 10)) begin errs++; $display("FAIL dl_flag k%0d got=%b exp=%b", k, dl, (k >= 10)); end
      end
      mb = 0; tick();
      checks++; if ({cnt, dl} !== {4'd0, 1'b1}) begin errs++; $display("FAIL dl_sticky got=%0d/%b exp=0/1", cnt, dl); end
      do_reset(); #1;
      checks++; if (dl !== 1'b0) begin errs++; $display("FAIL dl_rst got=%b exp=0", dl); end
   endtask

   task automatic test_random();
      int b, ia, ik, stall, quiet, old_pend;
      do_reset();
      m_mode = 0; m_pend = 0; m_cnt = 0; m_dl = 0; m_dd = 0;
      for (int n = 0; n < 1500; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         mb    = ($urandom_range(0, 4) == 0);
         es    = ($urandom_range(0, 4) == 0);
         red   = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 15) == 0) hrq = ~hrq;
         if ($urandom_range(0, 9) == 0) drq = ~drq;
         valid = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 1)) : 7'($urandom);
         if (rst) begin
            ia = 0; ik = 127;
         end else if (m_mode == 2) begin
            ia = 0; ik = 0;
         end else begin
            // A stall injects a bubble at stage b; only the stages beyond it move.
            if (mb || es) begin
               b  = mb ? 5 : 4;
               ia = 127 - ((2 << b) - 1);
               ik = 1 << b;
            end else if (red || m_pend) begin
               ia = 127; ik = 15;
            end else begin
               ia = 127; ik = 0;
            end
            if (m_mode == 1) begin ia = ia & ~1; ik = ik | 2; end
         end
         #2;
         checks++; if ({adv, kill} !== {7'(ia), 7'(ik)}) begin errs++; $display("FAIL rnd_ctl n%0d got=%h/%h exp=%h/%h", n, adv, kill, 7'(ia), 7'(ik)); end
         checks++; if ({hzd, halted} !== {(!rst && m_mode != 2), (!rst && m_mode == 2)}) begin errs++; $display("FAIL rnd_st n%0d got=%b%b mode=%0d", n, hzd, halted, m_mode); end
         tick();
         if (rst) begin
            m_mode = 0; m_pend = 0; m_cnt = 0; m_dl = 0; m_dd = 0;
         end else begin
            stall    = mb || es;
            quiet    = (valid[6:1] == 0);
            old_pend = m_pend;
            m_dd     = (m_mode == 1) && quiet;
            if (m_mode == 2) begin
               m_pend = m_pend | red;
               if (!hrq) m_mode = 0;
            end else begin
               if (stall) begin
                  if (m_cnt == 9) m_dl = 1;
                  m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
               end else begin
                  m_cnt = 0;
               end
               if (mb) m_pend = m_pend | red;
               else if (!es) m_pend = 0;
               if (m_mode == 1) begin
                  if (quiet) m_mode = 0;
               end else if (hrq) begin
                  if (!stall && !old_pend) m_mode = 2;
               end else if (drq) begin
                  m_mode = 1;
               end
            end
         end
         checks++; if ({dd, cnt, dl} !== {(!rst && m_dd != 0), (rst ? 4'd0 : 4'(m_cnt)), (!rst && m_dl != 0)}) begin errs++; $display("FAIL rnd_reg n%0d got=%b/%0d/%b exp=%0d/%0d/%0d", n, dd, cnt, dl, m_dd, m_cnt, m_dl); end
      end
      rst = 0;
   endtask

   initial begin
      clear_inputs(); rst = 1;
      test_reset();
      test_idle();
      test_ex_stall();
      test_redirect_busy();
      test_drain();
      test_halt();
      test_deadlock();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
